zvc_line_sequencer: RTL and testbench

// Issue controller for the zero-value line compressor. Accepts LIFM/mapping-table line pairs over valid/ready,

---
 rtl/zvc_line_sequencer_if.sv | 39 +++
 rtl/zvc_line_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_zvc_line_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zvc_line_sequencer_if.sv
// Line streams between the sequencer, its producer/consumer and the zero-value compressor.
// master is the sequencer side; slave is the environment (producer, consumer, compressor).
interface zvc_line_sequencer_if #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 32,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 3
);
  localparam int LW = LINE_SIZE * WORD_WIDTH;
  localparam int MW = LINE_SIZE * DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int NW = $clog2(LINE_SIZE + 1);

  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_lifm;
  logic [MW-1:0] in_mt;

  logic [LW-1:0] zvc_lifm_line;
  logic [MW-1:0] zvc_mt_line;
  logic [LW-1:0] zvc_lifm_comp;
  logic [MW-1:0] zvc_mt_comp;

  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_lifm;
  logic [MW-1:0] out_mt;
  logic [NW-1:0] out_nnz;
  logic          out_last;

  modport master (
    input  in_valid, in_lifm, in_mt, zvc_lifm_comp, zvc_mt_comp, out_ready,
    output in_ready, zvc_lifm_line, zvc_mt_line, out_valid, out_lifm, out_mt, out_nnz, out_last
  );

  modport slave (
    output in_valid, in_lifm, in_mt, zvc_lifm_comp, zvc_mt_comp, out_ready,
    input  in_ready, zvc_lifm_line, zvc_mt_line, out_valid, out_lifm, out_mt, out_nnz, out_last
  );
endinterface

// File: rtl/zvc_line_sequencer.sv
// Issue controller for the zero-value line compressor: credit-gated issue into a free-running
// compressor pipeline, in-flight tracking by a valid shift register, and an output FIFO.
module zvc_line_sequencer #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 32,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int PIPE_LAT      = 2,
  parameter int OUT_DEPTH     = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_lines,
  output logic                 busy,
  output logic                 done,
  zvc_line_sequencer_if.master bus
);
  localparam int LW  = LINE_SIZE * WORD_WIDTH;
  localparam int MTW = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int MW  = LINE_SIZE * MTW;
  localparam int NW  = $clog2(LINE_SIZE + 1);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int IW  = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] total;

  logic                 fire;
  logic                 last_in;
  logic                 credit_ok;
  logic [IW-1:0]        inflight;

  logic [PIPE_LAT-1:0]  vld_p;
  logic [PIPE_LAT-1:0]  last_p;
  logic [NW-1:0]        nnz_p [PIPE_LAT];

  logic [LW-1:0]        mem_lifm [OUT_DEPTH];
  logic [MW-1:0]        mem_mt   [OUT_DEPTH];
  logic [NW-1:0]        mem_nnz  [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] mem_last;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        fifo_count;
  logic                 head_valid;
  logic                 head_last;
  logic                 push;
  logic                 pop;

  function automatic logic [NW-1:0] count_nnz(input logic [MW-1:0] mt);
    logic [NW-1:0] n;
    n = '0;
    for (int i = 0; i < LINE_SIZE; i++)
      if (mt[i*MTW +: MTW] != '0) n = n + NW'(1);
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == OUT_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++)
      if (vld_p[i]) inflight = inflight + IW'(1);
  end

  // A slot is reserved for every line already in the compressor, so a push never finds the FIFO full.
  assign credit_ok    = (int'(fifo_count) + int'(inflight)) < OUT_DEPTH;
  assign bus.in_ready = (state == RUN) && (issued < total) && credit_ok;
  assign fire         = bus.in_valid && bus.in_ready;
  assign last_in      = (issued == total - CNT_WIDTH'(1));

  assign bus.zvc_lifm_line = fire ? bus.in_lifm : '0;
  assign bus.zvc_mt_line   = fire ? bus.in_mt   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      issued <= '0;
      total  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            total  <= num_lines;
            issued <= '0;
            if (num_lines != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            issued <= issued + CNT_WIDTH'(1);
            if (last_in) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0..p(PIPE_LAT-1): sideband tracking the line as it moves through the compressor
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fire;
      for (int i = 1; i < PIPE_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    nnz_p[0]  <= count_nnz(bus.in_mt);
    last_p[0] <= last_in;
    for (int i = 1; i < PIPE_LAT; i++) begin
      nnz_p[i]  <= nnz_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  // Pipe exit: compressor output is valid exactly when the tail valid bit is set
  assign push       = vld_p[PIPE_LAT-1];
  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid && bus.out_ready;
  assign head_last  = mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_lifm[wr_ptr] <= bus.zvc_lifm_comp;
      mem_mt[wr_ptr]   <= bus.zvc_mt_comp;
      mem_nnz[wr_ptr]  <= nnz_p[PIPE_LAT-1];
      mem_last[wr_ptr] <= last_p[PIPE_LAT-1];
    end
  end

  // Storage is not reset; gating on head_valid keeps the outputs at zero whenever the FIFO is empty.
  assign bus.out_valid = head_valid;
  assign bus.out_lifm  = head_valid ? mem_lifm[rd_ptr] : '0;
  assign bus.out_mt    = head_valid ? mem_mt[rd_ptr]   : '0;
  assign bus.out_nnz   = head_valid ? mem_nnz[rd_ptr]  : '0;
  assign bus.out_last  = head_valid && head_last;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> ((int'(fifo_count) < OUT_DEPTH) || pop));

endmodule

// File: tb/tb_zvc_line_sequencer.sv
// Directed bench for zvc_line_sequencer with a behavioural compressor (delay by PIPE_LAT, bitwise invert).
module tb_zvc_line_sequencer;
  localparam int WORD_WIDTH    = 8;
  localparam int LINE_SIZE     = 32;
  localparam int DIST_WIDTH    = 7;
  localparam int MAX_LIFM_RSIZ = 3;
  localparam int PIPE_LAT      = 2;
  localparam int OUT_DEPTH     = 4;
  localparam int CNT_WIDTH     = 16;
  localparam int LW  = LINE_SIZE * WORD_WIDTH;
  localparam int MTW = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int MW  = LINE_SIZE * MTW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [CNT_WIDTH-1:0] num_lines = '0;
  logic                 busy;
  logic                 done;

  zvc_line_sequencer_if #(.WORD_WIDTH(WORD_WIDTH), .LINE_SIZE(LINE_SIZE),
    .DIST_WIDTH(DIST_WIDTH), .MAX_LIFM_RSIZ(MAX_LIFM_RSIZ)) bus ();

  zvc_line_sequencer #(.WORD_WIDTH(WORD_WIDTH), .LINE_SIZE(LINE_SIZE), .DIST_WIDTH(DIST_WIDTH),
    .MAX_LIFM_RSIZ(MAX_LIFM_RSIZ), .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH),
    .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .busy(busy), .done(done), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lifm_of(input int k);
    logic [LW-1:0] v;
    for (int j = 0; j < LINE_SIZE; j++) v[j*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(k*16 + j + 1);
    return v;
  endfunction

  // Line k has words 0..(k mod LINE_SIZE) nonzero, so its nonzero count is (k mod LINE_SIZE)+1.
  function automatic logic [MW-1:0] mt_of(input int k);
    logic [MW-1:0] v;
    for (int j = 0; j < LINE_SIZE; j++)
      v[j*MTW +: MTW] = (j <= k % LINE_SIZE) ? MTW'(k*64 + j + 1) : '0;
    return v;
  endfunction

  int            line_idx = 0;
  logic          special = 1'b0;
  logic [MW-1:0] special_mt;

  assign bus.in_lifm = lifm_of(line_idx);
  assign bus.in_mt   = special ? special_mt : mt_of(line_idx);

  always @(posedge clk) if (bus.in_valid && bus.in_ready) line_idx <= line_idx + 1;

  logic [LW-1:0] cl [PIPE_LAT];
  logic [MW-1:0] cm [PIPE_LAT];
  always @(posedge clk) begin
    cl[0] <= bus.zvc_lifm_line;
    cm[0] <= bus.zvc_mt_line;
    for (int i = 1; i < PIPE_LAT; i++) begin
      cl[i] <= cl[i-1];
      cm[i] <= cm[i-1];
    end
  end
  assign bus.zvc_lifm_comp = ~cl[PIPE_LAT-1];
  assign bus.zvc_mt_comp   = ~cm[PIPE_LAT-1];

  logic [LW-1:0] q_lifm [$];
  logic [MW-1:0] q_mt   [$];
  int            q_nnz  [$];
  logic          q_last [$];
  int            done_cnt = 0;
  int            rdy_cnt  = 0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      q_lifm.push_back(bus.out_lifm);
      q_mt.push_back(bus.out_mt);
      q_nnz.push_back(int'(bus.out_nnz));
      q_last.push_back(bus.out_last);
    end
    if (done) done_cnt++;
    if (bus.in_ready) rdy_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      smp();
      c++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_pop(input int qi, input int line, input logic last, input string tag);
    logic [LW-1:0] el;
    logic [MW-1:0] em;
    el = ~lifm_of(line);
    em = ~mt_of(line);
    check({tag, "_present"}, q_last.size() > qi, 1'b1);
    if (q_last.size() > qi) begin
      check({tag, "_lifm"}, q_lifm[qi], el);
      check({tag, "_mt"}, q_mt[qi], em);
      check({tag, "_nnz"}, q_nnz[qi], (line % LINE_SIZE) + 1);
      check({tag, "_last"}, q_last[qi], last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, q0, r0, d0;
    logic [LW-1:0] el;
    logic [MW-1:0] em;
    special_mt = '0;
    special_mt[0*MTW +: MTW]  = 21'h000001;
    special_mt[5*MTW +: MTW]  = 21'h00005A;
    special_mt[9*MTW +: MTW]  = 21'h1FFFFF;
    special_mt[11*MTW +: MTW] = 21'h100000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, with in_valid raised while idle
    repeat (3) cyc();
    bus.in_valid = 1'b1;
    smp();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_nnz", bus.out_nnz, 0);
    check("rst_zvc_lifm", bus.zvc_lifm_line, 0);
    check("rst_zvc_mt", bus.zvc_mt_line, 0);
    cyc();
    reset = 1'b0;
    smp();
    check("idle_in_ready", bus.in_ready, 1'b0);
    check("idle_zvc_lifm", bus.zvc_lifm_line, 0);

    // Three-line tile at full rate
    cyc();
    base = line_idx; q0 = q_last.size(); r0 = rdy_cnt; d0 = done_cnt;
    bus.out_ready = 1'b1; start = 1'b1; num_lines = 16'd3;
    cyc();
    start = 1'b0;
    smp();
    check("t1_busy", busy, 1'b1);
    wait_done(50, "t1_done_seen");
    smp(); smp();
    check("t1_fired", line_idx - base, 3);
    check("t1_ready_cycles", rdy_cnt - r0, 3);
    check("t1_done_cycles", done_cnt - d0, 1);
    check("t1_pops", q_last.size() - q0, 3);
    for (int i = 0; i < 3; i++) check_pop(q0 + i, base + i, i == 2, "t1_pop");
    check("t1_busy_end", busy, 1'b0);

    // Single line with MT words 0,5,9,11 nonzero; latency and pass-through
    cyc();
    special = 1'b1; base = line_idx; start = 1'b1; num_lines = 16'd1;
    cyc();
    start = 1'b0;
    el = lifm_of(base);
    smp();
    check("t2_in_ready", bus.in_ready, 1'b1);
    check("t2_zvc_lifm", bus.zvc_lifm_line, el);
    check("t2_zvc_mt", bus.zvc_mt_line, special_mt);
    cyc(); cyc();
    smp();
    check("t2_out_valid_early", bus.out_valid, 1'b0);
    cyc();
    smp();
    el = ~lifm_of(base);
    em = ~special_mt;
    check("t2_out_valid", bus.out_valid, 1'b1);
    check("t2_nnz", bus.out_nnz, 4);
    check("t2_lifm", bus.out_lifm, el);
    check("t2_mt", bus.out_mt, em);
    check("t2_last", bus.out_last, 1'b1);
    wait_done(20, "t2_done_seen");
    cyc();
    special = 1'b0;

    // Back-pressure: ten lines with out_ready low
    base = line_idx; q0 = q_last.size(); r0 = rdy_cnt; d0 = done_cnt;
    bus.out_ready = 1'b0; start = 1'b1; num_lines = 16'd10;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    smp();
    check("t3_accepted", line_idx - base, OUT_DEPTH);
    check("t3_ready_cycles", rdy_cnt - r0, OUT_DEPTH);
    check("t3_in_ready_low", bus.in_ready, 1'b0);
    check("t3_busy", busy, 1'b1);
    el = ~lifm_of(base);
    check("t3_head_lifm", bus.out_lifm, el);
    cyc();
    bus.out_ready = 1'b1;
    wait_done(200, "t3_done_seen");
    smp();
    check("t3_pops", q_last.size() - q0, 10);
    check("t3_done_cycles", done_cnt - d0, 1);
    for (int i = 0; i < 10; i++) check_pop(q0 + i, base + i, i == 9, "t3_pop");

    // Zero-length tile
    cyc();
    r0 = rdy_cnt; d0 = done_cnt;
    start = 1'b1; num_lines = 16'd0;
    cyc();
    start = 1'b0;
    smp();
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b0);
    cyc();
    smp();
    check("t4_done_clear", done, 1'b0);
    repeat (3) cyc();
    smp();
    check("t4_ready_cycles", rdy_cnt - r0, 0);
    check("t4_done_cycles", done_cnt - d0, 1);

    // Reset with two lines in the compressor and two in the FIFO
    cyc();
    base = line_idx; d0 = done_cnt;
    bus.out_ready = 1'b0; start = 1'b1; num_lines = 16'd10;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    smp();
    check("t5_accepted", line_idx - base, 4);
    check("t5_out_valid_before", bus.out_valid, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    q0 = q_last.size();
    smp();
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_in_ready", bus.in_ready, 1'b0);
    repeat (6) cyc();
    smp();
    check("t5_no_pops", q_last.size() - q0, 0);
    check("t5_no_done", done_cnt - d0, 0);

    // start during RUN must not restart or resize the tile
    cyc();
    base = line_idx; q0 = q_last.size(); d0 = done_cnt;
    bus.in_valid = 1'b1; start = 1'b1; num_lines = 16'd3;
    cyc();
    num_lines = 16'd5;
    cyc();
    start = 1'b0;
    wait_done(50, "t6_done_seen");
    repeat (5) smp();
    check("t6_fired", line_idx - base, 3);
    check("t6_pops", q_last.size() - q0, 3);
    check("t6_done_cycles", done_cnt - d0, 1);
    check("t6_busy_end", busy, 1'b0);
    for (int i = 0; i < 3; i++) check_pop(q0 + i, base + i, i == 2, "t6_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
